// File: rtl/if_prefetch_unit.sv
// Fetch front end: PC generator, single-outstanding ROM request port and DEPTH-entry prefetch queue to ID.
// Latency: ROM accept to ID head is L+1 cycles (L = ROM response latency, >= 1).
// Backpressure: a queue slot is reserved per in-flight request; rom_ce_o drops when full or on redirect.
module if_prefetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       rom_ce_o,
  output logic [ADDR_W-1:0]          rom_addr_o,
  input  logic                       rom_ready_i,
  input  logic                       rom_valid_i,
  input  logic [DATA_W-1:0]          rom_data_i,
  input  logic                       stall_i,
  input  logic                       branch_flag_i,
  input  logic [ADDR_W-1:0]          branch_target_address_i,
  output logic [ADDR_W-1:0]          id_pc_o,
  output logic [DATA_W-1:0]          id_inst_o,
  output logic                       id_valid_o,
  output logic [$clog2(DEPTH+1)-1:0] q_count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int SUM_W = CNT_W + 1;

  typedef enum logic {SEQ, DS_OWED} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic              outstanding_q, outstanding_d;
  logic              discard_q, discard_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] pc_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_d [DEPTH];
  logic [DATA_W-1:0] inst_mem_q [DEPTH];
  logic [DATA_W-1:0] inst_mem_d [DEPTH];

  logic              head_vld, pop, redir, redir_multi;
  logic              resp, discard_now, push, accept;
  logic [SUM_W-1:0]  slots_used;

  // Handshake decode: response/push, pop/redirect, and request gating with slot reservation
  always_comb begin
    head_vld    = rst & (count_q != '0);
    pop         = head_vld & ~stall_i;
    redir       = pop & branch_flag_i & (state_q == SEQ);
    redir_multi = redir & (count_q >= CNT_W'(2));
    resp        = rom_valid_i & outstanding_q;
    // A redirect that drops younger entries also drops a response landing this cycle
    discard_now = discard_q | redir_multi;
    push        = resp & ~discard_now;
    // Occupied entries after this cycle's push plus any request still in flight
    slots_used  = {1'b0, count_q} + SUM_W'(push) + SUM_W'(outstanding_q & ~rom_valid_i);
    rom_ce_o    = rst & (~outstanding_q | rom_valid_i) & (slots_used < SUM_W'(DEPTH)) & ~branch_flag_i;
    accept      = rom_ce_o & rom_ready_i;
    rom_addr_o  = fetch_pc_q;
    id_valid_o  = head_vld;
    id_pc_o     = head_vld ? pc_mem_q[rd_ptr_q] : '0;
    id_inst_o   = head_vld ? inst_mem_q[rd_ptr_q] : '0;
    q_count_o   = rst ? count_q : '0;
  end

  // Next-state: fetch PC, outstanding tracking, queue pointers and delay-slot redirect handling
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    pend_tgt_d    = pend_tgt_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;

    if (resp) begin
      outstanding_d = 1'b0;
      discard_d     = 1'b0;
    end

    if (accept) begin
      outstanding_d = 1'b1;
      req_pc_d      = fetch_pc_q;
      // The delay-slot fetch has just gone out; the owed target follows it
      if (state_q == DS_OWED) begin
        fetch_pc_d = pend_tgt_q;
        state_d    = SEQ;
      end else begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    if (redir) begin
      if (count_q >= CNT_W'(2)) begin
        // Keep only the delay slot behind the popped branch
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        wr_ptr_d   = rd_ptr_q + PTR_W'(2);
        count_d    = CNT_W'(1);
        fetch_pc_d = branch_target_address_i;
        if (outstanding_q & ~rom_valid_i) discard_d = 1'b1;
      end else if (outstanding_q) begin
        // In-flight fetch is the delay slot and is kept
        fetch_pc_d = branch_target_address_i;
      end else begin
        // Delay slot not fetched yet: fetch branch+4 first, then the target
        state_d    = DS_OWED;
        pend_tgt_d = branch_target_address_i;
      end
    end
  end

  // Queue storage write port
  always_comb begin
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    if (push) begin
      pc_mem_d[wr_ptr_q]   = req_pc_q;
      inst_mem_d[wr_ptr_q] = rom_data_i;
    end
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= SEQ;
      fetch_pc_q    <= RESET_PC;
      req_pc_q      <= '0;
      pend_tgt_q    <= '0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      req_pc_q      <= req_pc_d;
      pend_tgt_q    <= pend_tgt_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Queue storage needs no reset; entries are only read when counted valid
  always_ff @(posedge clk) begin
    pc_mem_q   <= pc_mem_d;
    inst_mem_q <= inst_mem_d;
  end

endmodule
